// File: rtl/shift_seq.sv
// shift_seq: iterative 16-bit shifter, one single-bit step per clock.
// A start/busy/done handshake wraps a shift of 0-15 positions; busy and done
// are Moore outputs decoded from the state register.
module shift_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] in,
  input  logic [1:0]  shift,
  input  logic [3:0]  amt,
  output logic [15:0] sout,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] sout_q, sout_d;
  logic [1:0]  op_q, op_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept;

  // Single-bit step shared with the combinational shifter encoding.
  function automatic logic [15:0] step(input logic [15:0] val, input logic [1:0] op);
    logic [15:0] res;
    case (op)
      2'b01:   res = {val[14:0], 1'b0};
      2'b10:   res = {1'b0, val[15:1]};
      2'b11:   res = {val[15], val[15:1]};
      default: res = val;
    endcase
    return res;
  endfunction

  // Start is ignored while shifting; DONE accepts for back-to-back operation.
  assign accept = start && (state_q != StShift);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      sout_q  <= 16'h0000;
      op_q    <= 2'b00;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      sout_q  <= sout_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; zero-length ops go straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = (amt == 4'd0 || shift == 2'b00) ? StDone : StShift;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        if (cnt_q == 4'd1) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: capture on accept, step once per SHIFT cycle.
  always_comb begin
    sout_d = sout_q;
    op_d   = op_q;
    cnt_d  = cnt_q;
    if (accept) begin
      sout_d = in;
      op_d   = shift;
      cnt_d  = amt;
    end else if (state_q == StShift) begin
      sout_d = step(sout_q, op_q);
      cnt_d  = cnt_q - 4'd1;
    end
  end

  // Moore outputs decoded from state only.
  always_comb begin
    busy = (state_q == StShift);
    done = (state_q == StDone);
    sout = sout_q;
  end

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq with hand-computed expected results.
module tb_shift_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] din;
  logic [1:0]  sh;
  logic [3:0]  amt;
  logic [15:0] sout;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  shift_seq dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .in    (din),
    .shift (sh),
    .amt   (amt),
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Launch one op with a single-cycle start pulse and check result and timing.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [1:0] s,
                        input logic [3:0] n, input logic [15:0] exp, input int lat);
    int cyc;
    int bcnt;
    @(negedge clk);
    start = 1'b1; din = a; sh = s; amt = n;
    @(negedge clk);
    start = 1'b0;
    cyc  = 0;
    bcnt = 0;
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 16'(cyc), 16'(lat));
    check({tag, "_busycycles"}, 16'(bcnt), 16'(lat));
    check({tag, "_done"}, {15'd0, done}, 16'd1);
    check({tag, "_sout"}, sout, exp);
    @(negedge clk);
    check({tag, "_done_drop"}, {15'd0, done}, 16'd0);
    check({tag, "_idle_busy"}, {15'd0, busy}, 16'd0);
    check({tag, "_sout_hold"}, sout, exp);
  endtask

  initial begin
    int cyc;
    int dcnt;
    reset = 1'b1; start = 1'b0; din = 16'h0; sh = 2'b00; amt = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_sout", sout, 16'h0000);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    reset = 1'b0;

    run_op("lsl4",   16'hF00F, 2'b01, 4'd4,  16'h00F0, 4);
    run_op("lsr4",   16'hF00F, 2'b10, 4'd4,  16'h0F00, 4);
    run_op("asr4",   16'hF00F, 2'b11, 4'd4,  16'hFF00, 4);
    run_op("asr1",   16'hF00F, 2'b11, 4'd1,  16'hF807, 1);
    run_op("lsr15",  16'h8000, 2'b10, 4'd15, 16'h0001, 15);
    run_op("asr15",  16'h8000, 2'b11, 4'd15, 16'hFFFF, 15);
    run_op("lsl15",  16'h8000, 2'b01, 4'd15, 16'h0000, 15);
    run_op("pass7",  16'hA5A5, 2'b00, 4'd7,  16'hA5A5, 0);
    run_op("lsl0",   16'hA5A5, 2'b01, 4'd0,  16'hA5A5, 0);

    // Back-to-back: hold start from DONE, change operands mid-SHIFT.
    run_op("pre_b2b", 16'h0001, 2'b01, 4'd3, 16'h0008, 3);
    @(negedge clk);
    start = 1'b1; din = 16'h0001; sh = 2'b01; amt = 4'd3;
    cyc = 0;
    @(negedge clk);
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_first_done", {15'd0, done}, 16'd1);
    check("b2b_first_sout", sout, 16'h0008);
    din = 16'h0003; sh = 2'b01; amt = 4'd2;
    @(negedge clk);
    check("b2b_no_idle_busy", {15'd0, busy}, 16'd1);
    check("b2b_no_idle_done", {15'd0, done}, 16'd0);
    din = 16'hFFFF; sh = 2'b10; amt = 4'd5;
    @(negedge clk);
    check("b2b_ignore_busy", {15'd0, busy}, 16'd1);
    start = 1'b0;
    @(negedge clk);
    check("b2b_done", {15'd0, done}, 16'd1);
    check("b2b_sout", sout, 16'h000C);
    @(negedge clk);
    check("b2b_idle_done", {15'd0, done}, 16'd0);
    check("b2b_idle_sout", sout, 16'h000C);

    // Reset during the 3rd SHIFT cycle of an LSL-8.
    @(negedge clk);
    start = 1'b1; din = 16'h00FF; sh = 2'b01; amt = 4'd8;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_busy", {15'd0, busy}, 16'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_sout", sout, 16'h0000);
    check("midrst_busy", {15'd0, busy}, 16'd0);
    check("midrst_done", {15'd0, done}, 16'd0);
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("midrst_no_done", 16'(dcnt), 16'd0);
    run_op("post_rst", 16'hF00F, 2'b01, 4'd4, 16'h00F0, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_seq.md
# shift_seq

Iterative 16-bit shift unit for the lab datapath. It applies a multi-bit shift of 0–15 positions by repeating one single-bit step per clock. It uses the same 2-bit shift encoding as the combinational single-bit shifter, so a controller can issue shift-by-N without a barrel shifter. A start/busy/done handshake lets the controller FSM launch an operation and wait for its result.

## Interface
- No parameters. Data width is fixed at 16 and the shift count at 4 bits.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on a rising edge only when not busy.
- in  input  16  operand; captured when start is accepted.
- shift  input  2  operation, captured with start:
  - 00: pass-through
  - 01: logical left shift, 0 fills bit 0
  - 10: logical right shift, 0 fills bit 15
  - 11: arithmetic right shift, bit 15 replicated
- amt  input  4  shift count 0–15; captured with start.
- sout  output  16  result register; holds its value between operations.
- busy  output  1  high while shifting (state SHIFT).
- done  output  1  high for exactly one cycle when sout holds a new result.

## Operation
- FSM states:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1, done=0.
  - DONE: busy=0, done=1.
- busy and done are decoded directly from the state (Moore outputs).
- Internal registers: op[1:0] and cnt[3:0].
- Start accepted in IDLE or DONE with start=1:
  - sout<=in, op<=shift, cnt<=amt.
  - If amt==0 or shift==00, next state is DONE; otherwise SHIFT.
- SHIFT, on each edge:
  - sout<=one-bit step of sout per op, cnt<=cnt-1.
  - If cnt==1, next state is DONE; otherwise stay in SHIFT.
- DONE with start=0: next state IDLE; sout unchanged.
- DONE with start=1: accepted as above (back-to-back operation); done drops for at least the following cycle unless the new operation is zero-length.
- start while in SHIFT is ignored. in, shift and amt are don't-care while busy.
- Result equals the N-fold application of the single-bit step:
  - LSL N: in<<N.
  - LSR N: in>>N, zero-filled.
  - ASR N: sign-filled.
- N=15 on a right shift leaves only the MSB-derived bit(s).

## Timing
- Reset, at the edge where reset=1: state IDLE, sout=16'h0000, cnt=0, op=00, busy=0, done=0.
- Reset has priority over start and over any state, including mid-SHIFT; a partially shifted value is discarded.
- Numbering the accepting edge as edge 0, with n=amt and a shifting op:
  - busy is high after edges 0..n-1.
  - sout is final and done is high in the cycle after edge n.
  - Latency is n cycles from acceptance to done. Total occupancy is n+1 cycles including DONE.
- Zero-length op (amt=0 or shift=00): done is high in the cycle after edge 0, and sout=in.
- sout changes only at accept edges and SHIFT edges. It is stable through DONE and IDLE.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then in=16'hF00F, shift=01, amt=4, start pulsed 1 cycle:
  - busy is high for 4 cycles.
  - done pulses once with sout=16'h00F0.
  - Next cycle is IDLE with sout still 16'h00F0.
- in=16'hF00F:
  - shift=10, amt=4 -> sout=16'h0F00.
  - shift=11, amt=4 -> sout=16'hFF00.
  - shift=11, amt=1 -> 16'hF807.
  - Each result arrives after 4, 4 and 1 cycles respectively.
- in=16'h8000, amt=15:
  - LSR -> 16'h0001.
  - ASR -> 16'hFFFF.
  - LSL -> 16'h0000.
  - done asserts in the cycle after edge 15.
- Zero-length ops:
  - in=16'hA5A5, shift=00, amt=7 -> done next cycle, sout=16'hA5A5.
  - shift=01, amt=0 -> same.
- Start held high continuously from DONE with new operands (in=16'h0003, shift=01, amt=2):
  - Back-to-back acceptance occurs.
  - sout=16'h000C with no IDLE cycle in between.
  - A start pulse mid-SHIFT with different operands is ignored, and the original result is unchanged.
- Assert reset during the 3rd SHIFT cycle of an LSL-8:
  - Next cycle sout=16'h0000, busy=0, done=0.
  - No done pulse follows.
  - A subsequent start works normally.
